// File: rtl/etch_pkg.sv
// Shared definitions for the etch-a-sketch rotary-encoder path: quadrature
// Gray states, step directions and screen bounds.
package etch_pkg;

   typedef enum logic [1:0] {
      ST_00 = 2'b00,
      ST_01 = 2'b01,
      ST_11 = 2'b11,
      ST_10 = 2'b10
   } quad_state_t;

   localparam logic DIR_INC = 1'b1;
   localparam logic DIR_DEC = 1'b0;

   localparam int H_MAX = 639;
   localparam int V_MAX = 479;

   // Clockwise successor in the Gray cycle 00 -> 01 -> 11 -> 10 -> 00.
   function automatic quad_state_t gray_next_cw(input quad_state_t s);
      quad_state_t n;
      case (s)
         ST_00:   n = ST_01;
         ST_01:   n = ST_11;
         ST_11:   n = ST_10;
         default: n = ST_00;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/knob_quad_decoder_debounce_filter.sv
// Per-channel debounce: a level is accepted only after DEBOUNCE_CYCLES
// consecutive samples that differ from the currently filtered level.
module debounce_filter #(
   parameter int DEBOUNCE_CYCLES = 100000
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic din_sync,
   output logic dout,
   output logic busy
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] count_q, count_d;
   logic          level_q, level_d;

   always_comb begin
      count_d = '0;
      level_d = level_q;
      if (din_sync != level_q) begin
         if (count_q == COUNT_LAST) begin
            level_d = din_sync;
         end else begin
            count_d = count_q + CW'(1);
         end
      end
   end

   // Filtered level idles high to match the encoder pull-ups.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         level_q <= 1'b1;
      end else begin
         count_q <= count_d;
         level_q <= level_d;
      end
   end

   assign dout = level_q;
   assign busy = (count_q != '0);

endmodule

// File: rtl/knob_quad_decoder.sv
// One rotary-encoder axis: synchronise and debounce A/B, decode detents from
// the Gray sequence and keep a saturating cursor position.
module knob_quad_decoder
   import etch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int POS_MAX         = H_MAX,
   parameter int POS_INIT        = 320,
   parameter int STEP            = 1
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       enc_a,
   input  logic       enc_b,
   input  logic       clear,
   output logic [9:0] pos,
   output logic       step_pulse,
   output logic       step_dir,
   output logic       quad_err
);

   localparam logic [10:0] POS_MAX_W  = 11'(POS_MAX);
   localparam logic [10:0] POS_INIT_W = 11'(POS_INIT);
   localparam logic [10:0] STEP_W     = 11'(STEP);

   // Bit 1 carries channel A, bit 0 channel B, matching the {A,B} state order.
   logic [1:0]        meta_q, meta_d;
   logic [1:0]        sync_q, sync_d;
   logic [1:0]        filt;
   logic [1:0]        busy;
   quad_state_t       pair;
   quad_state_t       state_q, state_d;
   logic              primed_q, primed_d;
   logic signed [2:0] acc_q, acc_d;
   logic signed [3:0] acc_sum;
   logic              step_pulse_q, step_pulse_d;
   logic              step_dir_q, step_dir_d;
   logic              quad_err_q, quad_err_d;
   logic [9:0]        pos_q, pos_d;
   logic [10:0]       pos_wide, inc_sum;
   logic [9:0]        pos_inc, pos_dec;

   always_comb begin
      meta_d = {enc_a, enc_b};
      sync_d = meta_q;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_chan
         debounce_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_filter (
            .clk_100MHz(clk_100MHz),
            .reset     (reset),
            .din_sync  (sync_q[gi]),
            .dout      (filt[gi]),
            .busy      (busy[gi])
         );
      end
   endgenerate

   assign pair = quad_state_t'(filt);

   assign pos_wide = {1'b0, pos_q};
   assign inc_sum  = pos_wide + STEP_W;
   assign pos_inc  = (inc_sum > POS_MAX_W) ? POS_MAX_W[9:0] : inc_sum[9:0];
   assign pos_dec  = (pos_wide < STEP_W) ? 10'd0 : (pos_q - STEP_W[9:0]);

   always_comb begin
      state_d      = state_q;
      primed_d     = primed_q;
      acc_d        = acc_q;
      acc_sum      = {acc_q[2], acc_q};
      step_pulse_d = 1'b0;
      step_dir_d   = step_dir_q;
      quad_err_d   = 1'b0;

      if (!primed_q) begin
         // Adopt whatever pair is settled so the first real edge counts correctly.
         if (busy == 2'b00) begin
            state_d  = pair;
            primed_d = 1'b1;
         end
      end else if (pair != state_q) begin
         state_d = pair;
         if ((pair ^ state_q) == 2'b11) begin
            quad_err_d = 1'b1;
            acc_d      = '0;
         end else begin
            acc_sum = {acc_q[2], acc_q} +
                      ((pair == gray_next_cw(state_q)) ? 4'sd1 : -4'sd1);
            if (acc_sum == 4'sd4) begin
               step_pulse_d = 1'b1;
               step_dir_d   = DIR_INC;
               acc_d        = '0;
            end else if (acc_sum == -4'sd4) begin
               step_pulse_d = 1'b1;
               step_dir_d   = DIR_DEC;
               acc_d        = '0;
            end else if (pair == ST_11) begin
               acc_d = '0;
            end else begin
               acc_d = acc_sum[2:0];
            end
         end
      end

      pos_d = pos_q;
      if (clear) begin
         pos_d = POS_INIT_W[9:0];
      end else if (step_pulse_d) begin
         pos_d = (step_dir_d == DIR_INC) ? pos_inc : pos_dec;
      end
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         meta_q       <= 2'b11;
         sync_q       <= 2'b11;
         state_q      <= ST_11;
         primed_q     <= 1'b0;
         acc_q        <= '0;
         step_pulse_q <= 1'b0;
         step_dir_q   <= 1'b0;
         quad_err_q   <= 1'b0;
         pos_q        <= POS_INIT_W[9:0];
      end else begin
         meta_q       <= meta_d;
         sync_q       <= sync_d;
         state_q      <= state_d;
         primed_q     <= primed_d;
         acc_q        <= acc_d;
         step_pulse_q <= step_pulse_d;
         step_dir_q   <= step_dir_d;
         quad_err_q   <= quad_err_d;
         pos_q        <= pos_d;
      end
   end

   assign pos        = pos_q;
   assign step_pulse = step_pulse_q;
   assign step_dir   = step_dir_q;
   assign quad_err   = quad_err_q;

endmodule

// File: tb/tb_knob_quad_decoder.sv
// Bench for knob_quad_decoder: three instances (normal, high-bound, low-bound)
// share one stimulus stream and are checked every cycle against a detent model.
module tb_knob_quad_decoder;

   logic       clk;
   logic       rst;
   logic       enc_a;
   logic       enc_b;
   logic       clear;
   logic [9:0] pos_o        [3];
   logic       step_pulse_o [3];
   logic       step_dir_o   [3];
   logic       quad_err_o   [3];

   int n_checks = 0;
   int n_fail   = 0;
   int n_step   = 0;
   int n_err    = 0;

   localparam int P_INIT [3] = '{320, 636, 3};
   localparam int P_STEP [3] = '{1, 8, 8};

   knob_quad_decoder #(.DEBOUNCE_CYCLES(4), .POS_MAX(639), .POS_INIT(320), .STEP(1)) u_dut0 (
      .clk_100MHz(clk), .reset(rst), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
      .pos(pos_o[0]), .step_pulse(step_pulse_o[0]), .step_dir(step_dir_o[0]), .quad_err(quad_err_o[0]));
   knob_quad_decoder #(.DEBOUNCE_CYCLES(4), .POS_MAX(639), .POS_INIT(636), .STEP(8)) u_dut1 (
      .clk_100MHz(clk), .reset(rst), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
      .pos(pos_o[1]), .step_pulse(step_pulse_o[1]), .step_dir(step_dir_o[1]), .quad_err(quad_err_o[1]));
   knob_quad_decoder #(.DEBOUNCE_CYCLES(4), .POS_MAX(639), .POS_INIT(3), .STEP(8)) u_dut2 (
      .clk_100MHz(clk), .reset(rst), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
      .pos(pos_o[2]), .step_pulse(step_pulse_o[2]), .step_dir(step_dir_o[2]), .quad_err(quad_err_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [1:0] hist [$];
   logic [1:0] m_filt;
   logic [1:0] m_state;
   bit         m_primed;
   int         m_acc;
   bit         m_step, m_err, m_dir;
   int         m_pos [3];

   function automatic int gidx(input logic [1:0] p);
      case (p)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_step();
      int d;
      if (rst) begin
         hist.delete();
         for (int j = 0; j < 8; j++) hist.push_back(2'b11);
         m_filt = 2'b11; m_state = 2'b11; m_primed = 0; m_acc = 0;
         m_step = 0; m_err = 0; m_dir = 0;
         for (int i = 0; i < 3; i++) m_pos[i] = P_INIT[i];
      end else begin
         hist.push_front({enc_a, enc_b});
         void'(hist.pop_back());
         m_step = 0;
         m_err  = 0;
         if (!m_primed) begin
            m_primed = 1;
            m_state  = m_filt;
         end else if (m_filt != m_state) begin
            d = (gidx(m_filt) - gidx(m_state) + 4) % 4;
            if (d == 2) begin
               m_err = 1;
               m_acc = 0;
            end else begin
               m_acc += (d == 1) ? 1 : -1;
               if (m_acc == 4) begin
                  m_step = 1; m_dir = 1; m_acc = 0;
               end else if (m_acc == -4) begin
                  m_step = 1; m_dir = 0; m_acc = 0;
               end else if (m_filt == 2'b11) begin
                  m_acc = 0;
               end
            end
            m_state = m_filt;
         end
         for (int i = 0; i < 3; i++) begin
            if (clear) m_pos[i] = P_INIT[i];
            else if (m_step && m_dir) m_pos[i] = (m_pos[i] + P_STEP[i] > 639) ? 639 : m_pos[i] + P_STEP[i];
            else if (m_step) m_pos[i] = (m_pos[i] - P_STEP[i] < 0) ? 0 : m_pos[i] - P_STEP[i];
         end
         // A channel flips once four consecutive synchronised samples disagree with it.
         for (int c = 0; c < 2; c++) begin
            bit all_diff = 1;
            for (int j = 2; j < 6; j++) if (hist[j][c] == m_filt[c]) all_diff = 0;
            if (all_diff) m_filt[c] = ~m_filt[c];
         end
      end
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("pos[%0d]", i), pos_o[i], m_pos[i]);
         chk($sformatf("step_pulse[%0d]", i), step_pulse_o[i], m_step);
         chk($sformatf("step_dir[%0d]", i), step_dir_o[i], m_dir);
         chk($sformatf("quad_err[%0d]", i), quad_err_o[i], m_err);
      end
      chk("strobe_exclusive", step_pulse_o[0] & quad_err_o[0], 0);
      if (step_pulse_o[0]) n_step++;
      if (quad_err_o[0]) n_err++;
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [1:0] p, input int n);
      {enc_a, enc_b} = p;
      repeat (n) @(negedge clk);
   endtask

   task automatic pin_pos(input string tag, input int e0, input int e1, input int e2);
      chk({tag, "_pos0"}, pos_o[0], e0);
      chk({tag, "_pos1"}, pos_o[1], e1);
      chk({tag, "_pos2"}, pos_o[2], e2);
   endtask

   task automatic detent(input string tag, input bit cw, input int e0, input int e1, input int e2);
      logic [1:0] seq [4];
      if (cw) seq = '{2'b10, 2'b00, 2'b01, 2'b11};
      else    seq = '{2'b01, 2'b00, 2'b10, 2'b11};
      for (int j = 0; j < 3; j++) drive(seq[j], 10);
      {enc_a, enc_b} = seq[3];
      repeat (7) @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) chk({tag, "_pulse"}, step_pulse_o[i], 1);
      chk({tag, "_dir"}, step_dir_o[0], cw);
      pin_pos(tag, e0, e1, e2);
      @(negedge clk);
      repeat (5) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; enc_a = 1'b1; enc_b = 1'b1; clear = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      pin_pos("reset", 320, 636, 3);
      chk("reset_no_step", n_step, 0);
      chk("reset_no_err", n_err, 0);

      detent("cw1", 1, 321, 639, 11);

      drive(2'b01, 3);
      drive(2'b11, 12);
      pin_pos("bounce", 321, 639, 11);
      chk("bounce_steps", n_step, 1);

      detent("ccw1", 0, 320, 631, 3);

      drive(2'b10, 10);
      drive(2'b11, 12);
      chk("partial_steps", n_step, 2);
      drive(2'b00, 12);
      chk("illegal_err", n_err, 1);
      pin_pos("illegal", 320, 631, 3);
      drive(2'b01, 10);
      drive(2'b11, 12);
      chk("partial2_steps", n_step, 2);
      chk("partial2_err", n_err, 1);

      detent("cw2", 1, 321, 639, 11);
      detent("cw3_sat", 1, 322, 639, 19);
      detent("ccw2", 0, 321, 631, 11);
      detent("ccw3", 0, 320, 623, 3);
      detent("ccw4_sat", 0, 319, 615, 0);

      // Asynchronous reset in the middle of a detent.
      drive(2'b10, 10);
      drive(2'b00, 4);
      rst = 1'b1;
      #1;
      pin_pos("async_reset", 320, 636, 3);
      chk("async_reset_err", quad_err_o[0], 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_step = 0;
      drive(2'b00, 8);
      drive(2'b01, 10);
      drive(2'b11, 15);
      chk("mid_reset_steps", n_step, 0);
      pin_pos("mid_reset", 320, 636, 3);

      detent("cw4", 1, 321, 639, 11);

      // Clear landing on the same edge as a detent step.
      drive(2'b10, 10);
      drive(2'b00, 10);
      drive(2'b01, 10);
      {enc_a, enc_b} = 2'b11;
      repeat (6) @(posedge clk);
      #2;
      clear = 1'b1;
      @(posedge clk);
      #2;
      clear = 1'b0;
      chk("clear_step_pulse", step_pulse_o[0], 1);
      pin_pos("clear_wins", 320, 636, 3);
      repeat (10) @(negedge clk);
      pin_pos("after_clear", 320, 636, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
